// File: rtl/axi_uart_pkt_rx_pkg.sv
// axi_uart_pkt_rx_pkg: FSM states, default SOF and error-flag indices shared by the framers
package axi_uart_pkt_rx_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAY, S_CHK, S_DRAIN} state_t;
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam int ERR_W = 4;
    localparam int ERR_CHK = 0;
    localparam int ERR_LEN = 1;
    localparam int ERR_PAR = 2;
    localparam int ERR_TMO = 3;
endpackage

// File: rtl/axi_uart_pkt_rx_if.sv
// axi_uart_pkt_rx_if: byte stream in, payload stream out, frame status pulses
interface axi_uart_pkt_rx_if;
    logic [8:0] i_tdata;
    logic       i_tvalid;
    logic       i_tready;
    logic [7:0] o_tdata;
    logic       o_tvalid;
    logic       o_tlast;
    logic       o_tready;
    logic       frame_ok;
    logic       err_chk;
    logic       err_len;
    logic       err_par;
    logic       err_timeout;
    modport master (
        output i_tdata, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tvalid, o_tlast, frame_ok, err_chk, err_len, err_par, err_timeout
    );
    modport slave (
        input  i_tdata, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tvalid, o_tlast, frame_ok, err_chk, err_len, err_par, err_timeout
    );
endinterface

// File: rtl/axi_uart_pkt_buf.sv
// axi_uart_pkt_buf: simple dual-port 8-bit frame buffer, synchronous write and read
module axi_uart_pkt_buf #(
    parameter int DEPTH = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/axi_uart_pkt_rx.sv
// axi_uart_pkt_rx: SOF|LEN|PAYLOAD|CHK deframer releasing checksum-verified payloads as a stream
module axi_uart_pkt_rx
    import axi_uart_pkt_rx_pkg::*;
#(
    parameter logic [7:0] SOF = SOF_DEFAULT,
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic rst,
    axi_uart_pkt_rx_if.slave bus
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [7:0] MAX_L = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    state_t state, state_n;
    logic [7:0] len, chk, d, rdata;
    logic [CW-1:0] cnt, rd, raddr, len_last;
    logic [TW-1:0] tmo;
    logic [ERR_W-1:0] err, err_n;
    logic ok, ok_n, par, acc, drain, hs, last, we;
    assign d = bus.i_tdata[7:0];
    assign par = bus.i_tdata[8];
    assign drain = state == S_DRAIN;
    assign bus.i_tready = rst && !drain;
    assign acc = bus.i_tvalid && bus.i_tready;
    assign len_last = CW'(len - 8'd1);
    assign last = rd == len_last;
    assign hs = drain && bus.o_tready;
    assign we = state == S_PAY && acc && !par;
    // Read one ahead on a handshake so the registered RAM output streams without bubbles
    assign raddr = (!drain || (hs && last)) ? '0 : rd + CW'(hs);
    assign bus.o_tvalid = drain;
    assign bus.o_tdata = drain ? rdata : '0;
    assign bus.o_tlast = drain && last;
    assign bus.frame_ok = ok;
    assign bus.err_chk = err[ERR_CHK];
    assign bus.err_len = err[ERR_LEN];
    assign bus.err_par = err[ERR_PAR];
    assign bus.err_timeout = err[ERR_TMO];
    axi_uart_pkt_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk(clk), .we(we), .waddr(AW'(cnt)), .wdata(d), .raddr(AW'(raddr)), .rdata(rdata)
    );
    always_comb begin
        state_n = state;
        err_n = '0;
        ok_n = 1'b0;
        case (state)
            S_IDLE: state_n = (acc && !par && d == SOF) ? S_LEN : S_IDLE;
            S_DRAIN: state_n = (hs && last) ? S_IDLE : S_DRAIN;
            S_LEN, S_PAY, S_CHK: begin
                if (acc && par) begin
                    err_n[ERR_PAR] = 1'b1;
                    state_n = S_IDLE;
                end else if (acc && state == S_LEN) begin
                    err_n[ERR_LEN] = d == 8'd0 || d > MAX_L;
                    state_n = err_n[ERR_LEN] ? S_IDLE : S_PAY;
                end else if (acc && state == S_PAY) begin
                    state_n = cnt == len_last ? S_CHK : S_PAY;
                end else if (acc) begin
                    ok_n = d == chk;
                    err_n[ERR_CHK] = !ok_n;
                    state_n = ok_n ? S_DRAIN : S_IDLE;
                end else if (tmo == TMO_LAST) begin
                    err_n[ERR_TMO] = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            len <= '0;
            chk <= '0;
            cnt <= '0;
            rd <= '0;
            tmo <= '0;
            err <= '0;
            ok <= 1'b0;
        end else begin
            state <= state_n;
            err <= err_n;
            ok <= ok_n;
            tmo <= (state == S_IDLE || drain || acc) ? '0 : tmo + TW'(1);
            rd <= drain ? rd + CW'(hs) : '0;
            if (acc && state == S_LEN) begin
                len <= d;
                chk <= d;
                cnt <= '0;
            end
            if (we) begin
                chk <= chk ^ d;
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_axi_uart_pkt_rx.sv
// tb_axi_uart_pkt_rx: directed frames with hand-computed payloads, checksums and pulses
module tb_axi_uart_pkt_rx;
    localparam int MAX_LEN = 64;
    localparam int TIMEOUT = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    axi_uart_pkt_rx_if ifc();
    axi_uart_pkt_rx #(.SOF(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(ifc)
    );
    always #5 clk = ~clk;
    int vectors = 0;
    int fails = 0;
    int n_ok = 0, n_okv = 0, n_chk = 0, n_len = 0, n_par = 0, n_tmo = 0, n_val = 0;
    int s_ok, s_okv, s_chk, s_len, s_par, s_tmo, s_val, s_got;
    logic [8:0] got[$];
    logic [8:0] fq[$];

    always @(negedge clk) begin
        if (ifc.o_tvalid === 1'b1 && ifc.o_tready === 1'b1) got.push_back({ifc.o_tlast, ifc.o_tdata});
        n_val += int'(ifc.o_tvalid === 1'b1);
        n_ok += int'(ifc.frame_ok === 1'b1);
        n_okv += int'(ifc.frame_ok === 1'b1 && ifc.o_tvalid === 1'b1);
        n_chk += int'(ifc.err_chk === 1'b1);
        n_len += int'(ifc.err_len === 1'b1);
        n_par += int'(ifc.err_par === 1'b1);
        n_tmo += int'(ifc.err_timeout === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int errs();
        return (n_chk - s_chk) + (n_len - s_len) + (n_par - s_par) + (n_tmo - s_tmo);
    endfunction

    task automatic snap();
        s_ok = n_ok; s_okv = n_okv; s_chk = n_chk; s_len = n_len;
        s_par = n_par; s_tmo = n_tmo; s_val = n_val; s_got = got.size();
    endtask

    task automatic send_byte(input logic [8:0] b);
        int n = 0;
        ifc.i_tdata = b;
        ifc.i_tvalid = 1'b1;
        @(negedge clk);
        while (ifc.i_tready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++; fails++;
            $display("FAIL send_stall byte=%h i_tready=%b want=1", b, ifc.i_tready);
        end
        @(posedge clk);
        #1;
        ifc.i_tvalid = 1'b0;
    endtask

    task automatic send_fq();
        foreach (fq[i]) send_byte(fq[i]);
    endtask

    task automatic test_reset();
        ifc.i_tvalid = 1'b0;
        ifc.i_tdata = '0;
        ifc.o_tready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (ifc.i_tready !== 1'b0) begin fails++; $display("FAIL rst_i_tready got=%b want=0", ifc.i_tready); end
        vectors++; if ({ifc.o_tvalid, ifc.o_tlast, ifc.o_tdata} !== 10'd0) begin fails++; $display("FAIL rst_out got=%h want=0", {ifc.o_tvalid, ifc.o_tlast, ifc.o_tdata}); end
        vectors++; if ({ifc.frame_ok, ifc.err_chk, ifc.err_len, ifc.err_par, ifc.err_timeout} !== 5'd0) begin fails++; $display("FAIL rst_flags got=%b want=00000", {ifc.frame_ok, ifc.err_chk, ifc.err_len, ifc.err_par, ifc.err_timeout}); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (ifc.i_tready !== 1'b1) begin fails++; $display("FAIL idle_i_tready got=%b want=1", ifc.i_tready); end
    endtask

    task automatic test_good_frame();
        snap();
        fq = {9'h0A5, 9'h003, 9'h011, 9'h022, 9'h033, 9'h003};
        send_fq();
        vectors++; if ({ifc.o_tvalid, ifc.frame_ok, ifc.o_tdata} !== {1'b1, 1'b1, 8'h11}) begin fails++; $display("FAIL good_first got=%h want=311", {ifc.o_tvalid, ifc.frame_ok, ifc.o_tdata}); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (got.size() - s_got != 3) begin fails++; $display("FAIL good_count got=%0d want=3", got.size() - s_got); end
        else begin
            vectors++; if ({got[s_got], got[s_got+1], got[s_got+2]} !== {9'h011, 9'h022, 9'h133}) begin fails++; $display("FAIL good_data got=%h %h %h want=011 022 133", got[s_got], got[s_got+1], got[s_got+2]); end
        end
        vectors++; if ({ifc.o_tvalid, ifc.i_tready} !== 2'b01) begin fails++; $display("FAIL good_after got=%b want=01", {ifc.o_tvalid, ifc.i_tready}); end
        vectors++; if (n_ok - s_ok != 1 || n_okv - s_okv != 1) begin fails++; $display("FAIL good_ok got=%0d/%0d want=1/1", n_ok - s_ok, n_okv - s_okv); end
        vectors++; if (errs() != 0) begin fails++; $display("FAIL good_errs got=%0d want=0", errs()); end
    endtask

    task automatic test_bad_chk();
        snap();
        fq = {9'h0A5, 9'h002, 9'h0AA, 9'h0BB, 9'h000};
        send_fq();
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (n_chk - s_chk != 1 || errs() != 1) begin fails++; $display("FAIL chk_err got=%0d/%0d want=1/1", n_chk - s_chk, errs()); end
        vectors++; if (n_val - s_val != 0 || n_ok - s_ok != 0) begin fails++; $display("FAIL chk_noout got=%0d/%0d want=0/0", n_val - s_val, n_ok - s_ok); end
        snap();
        fq = {9'h0A5, 9'h002, 9'h0AA, 9'h0BB, 9'h013};
        send_fq();
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (got.size() - s_got != 2) begin fails++; $display("FAIL chk_next_count got=%0d want=2", got.size() - s_got); end
        else begin
            vectors++; if ({got[s_got], got[s_got+1]} !== {9'h0AA, 9'h1BB}) begin fails++; $display("FAIL chk_next_data got=%h %h want=0aa 1bb", got[s_got], got[s_got+1]); end
        end
        vectors++; if (n_ok - s_ok != 1 || errs() != 0) begin fails++; $display("FAIL chk_next_ok got=%0d/%0d want=1/0", n_ok - s_ok, errs()); end
    endtask

    task automatic test_len();
        snap();
        fq = {9'h0A5, 9'h000, 9'h0A5, 9'h041, 9'h0A5, 9'h001, 9'h07E, 9'h07F};
        send_fq();
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (n_len - s_len != 2 || errs() != 2) begin fails++; $display("FAIL len_err got=%0d/%0d want=2/2", n_len - s_len, errs()); end
        vectors++; if (got.size() - s_got != 1) begin fails++; $display("FAIL len_count got=%0d want=1", got.size() - s_got); end
        else begin
            vectors++; if (got[s_got] !== 9'h17E) begin fails++; $display("FAIL len_data got=%h want=17e", got[s_got]); end
        end
        vectors++; if (n_ok - s_ok != 1) begin fails++; $display("FAIL len_ok got=%0d want=1", n_ok - s_ok); end
    endtask

    task automatic test_max_len();
        logic [7:0] c;
        int k = 0;
        int bad = 0;
        snap();
        c = 8'h40;
        fq = {9'h0A5, 9'h040};
        for (int i = 0; i < 64; i++) begin
            fq.push_back({1'b0, 8'(i * 3 + 1)});
            c ^= 8'(i * 3 + 1);
        end
        fq.push_back({1'b0, c});
        send_fq();
        while (got.size() - s_got < 64 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        vectors++; if (k != 64) begin fails++; $display("FAIL max_cycles got=%0d want=64", k); end
        if (got.size() - s_got >= 64)
            for (int i = 0; i < 64; i++) bad += int'(got[s_got+i] !== {i == 63, 8'(i * 3 + 1)});
        else bad = 99;
        vectors++; if (bad != 0) begin fails++; $display("FAIL max_data bad=%0d want=0", bad); end
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (n_ok - s_ok != 1 || errs() != 0) begin fails++; $display("FAIL max_ok got=%0d/%0d want=1/0", n_ok - s_ok, errs()); end
    endtask

    task automatic test_parity();
        snap();
        fq = {9'h05A, 9'h077, 9'h1A5, 9'h0A5, 9'h002, 9'h011, 9'h122,
              9'h0A5, 9'h002, 9'h1A5, 9'h001, 9'h055, 9'h054};
        send_fq();
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (n_par - s_par != 2 || errs() != 2) begin fails++; $display("FAIL par_err got=%0d/%0d want=2/2", n_par - s_par, errs()); end
        vectors++; if (n_val - s_val != 0 || n_ok - s_ok != 0) begin fails++; $display("FAIL par_noout got=%0d/%0d want=0/0", n_val - s_val, n_ok - s_ok); end
    endtask

    task automatic test_timeout();
        snap();
        fq = {9'h0A5, 9'h002, 9'h011};
        send_fq();
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        vectors++; if (ifc.err_timeout !== 1'b0) begin fails++; $display("FAIL tmo_early got=%b want=0", ifc.err_timeout); end
        @(posedge clk);
        #1;
        vectors++; if (ifc.err_timeout !== 1'b1) begin fails++; $display("FAIL tmo_pulse got=%b want=1", ifc.err_timeout); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (n_tmo - s_tmo != 1 || errs() != 1) begin fails++; $display("FAIL tmo_once got=%0d/%0d want=1/1", n_tmo - s_tmo, errs()); end
        fq = {9'h0A5, 9'h001, 9'h033, 9'h032};
        send_fq();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (got.size() - s_got != 1 || got[got.size()-1] !== 9'h133) begin fails++; $display("FAIL tmo_next got=%0d want=1 entry 133", got.size() - s_got); end
    endtask

    task automatic test_timeout_win();
        snap();
        fq = {9'h0A5, 9'h002, 9'h011};
        send_fq();
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        send_byte(9'h022);
        send_byte(9'h031);
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (n_tmo - s_tmo != 0) begin fails++; $display("FAIL win_tmo got=%0d want=0", n_tmo - s_tmo); end
        vectors++; if (got.size() - s_got != 2) begin fails++; $display("FAIL win_count got=%0d want=2", got.size() - s_got); end
        else begin
            vectors++; if ({got[s_got], got[s_got+1]} !== {9'h011, 9'h122}) begin fails++; $display("FAIL win_data got=%h %h want=011 122", got[s_got], got[s_got+1]); end
        end
    endtask

    task automatic test_back_pressure();
        logic [5:0] rdy = 6'b111001;
        logic [10:0] exp_v;
        int idx = 0;
        ifc.o_tready = 1'b0;
        fq = {9'h0A5, 9'h004, 9'h001, 9'h002, 9'h003, 9'h004, 9'h000};
        send_fq();
        for (int k = 0; k < 6; k++) begin
            ifc.o_tready = rdy[k];
            @(negedge clk);
            exp_v = {1'b1, idx == 3, 8'(idx + 1), 1'b0};
            vectors++; if ({ifc.o_tvalid, ifc.o_tlast, ifc.o_tdata, ifc.i_tready} !== exp_v) begin fails++; $display("FAIL bp_cycle%0d got=%h want=%h", k, {ifc.o_tvalid, ifc.o_tlast, ifc.o_tdata, ifc.i_tready}, exp_v); end
            if (rdy[k]) idx++;
            @(posedge clk);
            #1;
        end
        ifc.o_tready = 1'b1;
        vectors++; if ({ifc.o_tvalid, ifc.i_tready} !== 2'b01) begin fails++; $display("FAIL bp_after got=%b want=01", {ifc.o_tvalid, ifc.i_tready}); end
    endtask

    task automatic test_reset_mid_drain();
        snap();
        ifc.o_tready = 1'b0;
        fq = {9'h0A5, 9'h002, 9'h011, 9'h022, 9'h031};
        send_fq();
        @(posedge clk);
        #1;
        vectors++; if (ifc.o_tvalid !== 1'b1) begin fails++; $display("FAIL mid_valid got=%b want=1", ifc.o_tvalid); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++; if ({ifc.i_tready, ifc.o_tvalid, ifc.o_tlast, ifc.o_tdata, ifc.frame_ok, ifc.err_chk, ifc.err_len, ifc.err_par, ifc.err_timeout} !== 16'd0) begin fails++; $display("FAIL mid_rst got=%h want=0000", {ifc.i_tready, ifc.o_tvalid, ifc.o_tlast, ifc.o_tdata, ifc.frame_ok, ifc.err_chk, ifc.err_len, ifc.err_par, ifc.err_timeout}); end
        rst = 1'b1;
        ifc.o_tready = 1'b1;
        @(posedge clk);
        #1;
        fq = {9'h0A5, 9'h001, 9'h05C, 9'h05D};
        send_fq();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (got.size() - s_got != 1 || got[got.size()-1] !== 9'h15C) begin fails++; $display("FAIL mid_fresh got=%0d want=1 entry 15c", got.size() - s_got); end
        vectors++; if (n_ok - s_ok != 2 || errs() != 0) begin fails++; $display("FAIL mid_ok got=%0d/%0d want=2/0", n_ok - s_ok, errs()); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_len();
        test_max_len();
        test_parity();
        test_timeout();
        test_timeout_win();
        test_back_pressure();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
